sid_wave_lut: RTL and testbench

SID_WAVE_LUT -- requirements
Module: sid_wave_lut

---
 rtl/sid_wave_lut.sv | 261 ++++++++++++++++++++++++++
 tb/tb_sid_wave_lut.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_wave_lut.sv
// ---------------------------------------------------------------------------
// sid_wave_lut -- shared combined-waveform lookup for multiple SID voices.
//
// Each voice posts a lookup (table select + accumulator value) into its own
// one-deep pending slot. A round-robin arbiter grants one pending voice per
// cycle into a three-stage pipeline:
//   grant -> address/voice register -> synchronous ROM read -> out_data write
// An uncontended request therefore shows up on out_valid three edges after
// the edge that accepted it.
//
// Tables (8-bit, indexed by the top 12 accumulator bits):
//   mode 00 pulse+saw, 01 pulse+tri, 10 saw+tri, 11 pulse+saw+tri
// The table contents are a synthetic model of the combined waveforms built
// from the saw ramp (idx[11:4]) and the folded triangle (idx[10:3], inverted
// on the falling half).
//
// Configuration macro: SID_WAVE_PST_EN
//   defined   : the pulse+saw+tri table is built and mode 11 reads it.
//   undefined : no fourth table; mode 11 returns 0 with unchanged timing.
//
// Ports:
//   clock, reset          clock, async active-high reset
//   req_valid [V]         per-voice lookup strobe
//   req_mode  [2V]        per-voice table select
//   req_wave  [ACC_W*V]   per-voice accumulator value
//   out_valid [V]         pulse when that voice's out_data is updated
//   out_data  [OUT_W*V]   per-voice result, table byte in the MSBs
//   overrun   [V]         pulse when a pending request was replaced
// ---------------------------------------------------------------------------

// Per-voice slot, overrun flag and output register.
module sid_wave_lane #(
    parameter int OUT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    input  logic [1:0]       mode,
    input  logic [11:0]      idx,
    input  logic             grant,
    input  logic             wr_en,
    input  logic [7:0]       wr_byte,
    output logic             pending,
    output logic [1:0]       slot_mode,
    output logic [11:0]      slot_idx,
    output logic             overrun,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending   <= 1'b0;
            slot_mode <= '0;
            slot_idx  <= '0;
            overrun   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            // A request landing on the granted cycle is not a loss: the old
            // contents were already copied into the pipeline this edge.
            overrun <= req && pending && !grant;
            if (req) begin
                pending   <= 1'b1;
                slot_mode <= mode;
                slot_idx  <= idx;
            end else if (grant) begin
                pending   <= 1'b0;
            end
            out_valid <= wr_en;
            if (wr_en)
                out_data <= OUT_W'(wr_byte) << (OUT_W - 8);
        end
    end
endmodule

module sid_wave_lut #(
    parameter int VOICES = 3,
    parameter int ACC_W  = 12,
    parameter int OUT_W  = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [VOICES-1:0]       req_valid,
    input  logic [2*VOICES-1:0]     req_mode,
    input  logic [ACC_W*VOICES-1:0] req_wave,
    output logic [VOICES-1:0]       out_valid,
    output logic [OUT_W*VOICES-1:0] out_data,
    output logic [VOICES-1:0]       overrun
);
    localparam int VW     = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int STAGES = 2;

    // ---------------- table generators ----------------
    function automatic logic [7:0] f_saw(input logic [11:0] i);
        return i[11:4];
    endfunction

    function automatic logic [7:0] f_tri(input logic [11:0] i);
        return i[11] ? ~i[10:3] : i[10:3];
    endfunction

    // Quadratic ramp that saturates once the square leaves the byte range.
    function automatic logic [7:0] f_ps(input logic [11:0] i);
        logic [23:0] sq;
        sq = 24'(i) * 24'(i);
        return (sq[23:12] > 12'd255) ? 8'hFF : sq[19:12];
    endfunction

    function automatic logic [7:0] f_pt(input logic [11:0] i);
        logic [15:0] t2;
        t2 = 16'(f_tri(i)) * 16'(f_tri(i));
        return t2[15:8];
    endfunction

    function automatic logic [7:0] f_st(input logic [11:0] i);
        return f_saw(i) & f_tri(i);
    endfunction

`ifdef SID_WAVE_PST_EN
    function automatic logic [7:0] f_pst(input logic [11:0] i);
        return f_ps(i) & f_st(i);
    endfunction
`endif

    // ---------------- ROMs (constant-filled at elaboration) ----------------
    logic [7:0] rom_ps [4096];
    logic [7:0] rom_pt [4096];
    logic [7:0] rom_st [4096];
`ifdef SID_WAVE_PST_EN
    logic [7:0] rom_pst [4096];
`endif

    for (genvar a = 0; a < 4096; a++) begin : g_rom
        assign rom_ps[a] = f_ps(12'(a));
        assign rom_pt[a] = f_pt(12'(a));
        assign rom_st[a] = f_st(12'(a));
`ifdef SID_WAVE_PST_EN
        assign rom_pst[a] = f_pst(12'(a));
`endif
    end

    // ---------------- round-robin arbiter ----------------
    logic [VOICES-1:0]       pending;
    logic [VOICES-1:0]       grant;
    logic [VOICES-1:0][1:0]  slot_mode;
    logic [VOICES-1:0][11:0] slot_idx;
    logic [VW-1:0]           rr_ptr;   // last granted voice
    logic [VW:0]             pick;
    logic                    gnt_any;
    logic [VW-1:0]           gnt_vid;

    // Returns {found, voice}: first pending voice after 'last', wrapping.
    function automatic logic [VW:0] rr_pick(input logic [VOICES-1:0] pend,
                                            input logic [VW-1:0]     last);
        logic [VW:0] r;
        int          c;
        r = '0;
        for (int k = 0; k < VOICES; k++) begin
            c = (int'(last) + 1 + k) % VOICES;
            if (!r[VW] && pend[c])
                r = {1'b1, c[VW-1:0]};
        end
        return r;
    endfunction

    assign pick    = rr_pick(pending, rr_ptr);
    assign gnt_any = pick[VW];
    assign gnt_vid = pick[VW-1:0];

    always_comb begin
        grant = '0;
        if (gnt_any)
            grant[gnt_vid] = 1'b1;
    end

    // ---------------- pipeline ----------------
    logic [STAGES:1] vld_pipe;
    logic [VW-1:0]   s1_vid, s2_vid;
    logic [1:0]      s1_mode, s2_mode;
    logic [11:0]     s1_idx;
    logic [7:0]      rd_ps, rd_pt, rd_st;
`ifdef SID_WAVE_PST_EN
    logic [7:0]      rd_pst;
`endif
    logic [7:0]      sel_byte;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            rr_ptr   <= VW'(VOICES - 1);
            s1_vid   <= '0;
            s1_mode  <= '0;
            s1_idx   <= '0;
            s2_vid   <= '0;
            s2_mode  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], gnt_any};
            if (gnt_any) begin
                rr_ptr  <= gnt_vid;
                s1_vid  <= gnt_vid;
                s1_mode <= slot_mode[gnt_vid];
                s1_idx  <= slot_idx[gnt_vid];
            end
            s2_vid  <= s1_vid;
            s2_mode <= s1_mode;
        end
    end

    // Synchronous table reads; qualification comes from vld_pipe, so these
    // registers need no reset.
    always_ff @(posedge clock) begin
        rd_ps <= rom_ps[s1_idx];
        rd_pt <= rom_pt[s1_idx];
        rd_st <= rom_st[s1_idx];
`ifdef SID_WAVE_PST_EN
        rd_pst <= rom_pst[s1_idx];
`endif
    end

    always_comb begin
        sel_byte = 8'h00;
        case (s2_mode)
            2'd0:    sel_byte = rd_ps;
            2'd1:    sel_byte = rd_pt;
            2'd2:    sel_byte = rd_st;
            default: begin
`ifdef SID_WAVE_PST_EN
                sel_byte = rd_pst;
`else
                sel_byte = 8'h00;
`endif
            end
        endcase
    end

    // ---------------- voice lanes ----------------
    for (genvar v = 0; v < VOICES; v++) begin : g_lane
        if (ACC_W > 12) begin : g_lsb
            // Fractional accumulator bits below the table index are dropped.
            logic unused_lsb;
            assign unused_lsb = ^req_wave[v*ACC_W +: ACC_W-12];
        end

        sid_wave_lane #(.OUT_W(OUT_W)) u_lane (
            .clock     (clock),
            .reset     (reset),
            .req       (req_valid[v]),
            .mode      (req_mode[2*v +: 2]),
            .idx       (req_wave[v*ACC_W + ACC_W-12 +: 12]),
            .grant     (grant[v]),
            .wr_en     (vld_pipe[STAGES] && (s2_vid == VW'(v))),
            .wr_byte   (sel_byte),
            .pending   (pending[v]),
            .slot_mode (slot_mode[v]),
            .slot_idx  (slot_idx[v]),
            .overrun   (overrun[v]),
            .out_valid (out_valid[v]),
            .out_data  (out_data[v*OUT_W +: OUT_W])
        );
    end
endmodule

// File: tb/tb_sid_wave_lut.sv
module tb_sid_wave_lut;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [5:0]  req_mode  = '0;
    logic [35:0] req_wave  = '0;
    logic [2:0]  out_valid;
    logic [23:0] out_data;
    logic [2:0]  overrun;

    logic [1:0]  w_req_valid = '0;
    logic [3:0]  w_req_mode  = '0;
    logic [31:0] w_req_wave  = '0;
    logic [1:0]  w_out_valid;
    logic [23:0] w_out_data;
    logic [1:0]  w_overrun;

    int errors = 0;
    int checks = 0;

    sid_wave_lut dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_mode(req_mode), .req_wave(req_wave),
        .out_valid(out_valid), .out_data(out_data), .overrun(overrun)
    );

    sid_wave_lut #(.VOICES(2), .ACC_W(16), .OUT_W(12)) dut_w (
        .clock(clock), .reset(reset),
        .req_valid(w_req_valid), .req_mode(w_req_mode), .req_wave(w_req_wave),
        .out_valid(w_out_valid), .out_data(w_out_data), .overrun(w_overrun)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    typedef struct { int due; int v; int val; } res_t;
    res_t       sched[$];
    int         m_pend[3];
    int         m_mode[3];
    int         m_idx[3];
    int         m_last;
    int         cyc;
    logic [2:0] m_ov, m_ovr;
    logic [7:0] m_byte[3];

    function automatic int ref_byte(input int mode, input int idx);
        int saw, tri_v, ps, pt, st;
        saw   = idx / 16;
        tri_v = (idx < 2048) ? idx / 8 : (4095 - idx) / 8;
        ps    = (idx * idx) / 4096;
        if (ps > 255) ps = 255;
        pt    = (tri_v * tri_v) / 256;
        st    = saw & tri_v;
        case (mode)
            0: return ps;
            1: return pt;
            2: return st;
`ifdef SID_WAVE_PST_EN
            default: return ps & st;
`else
            default: return 0;
`endif
        endcase
    endfunction

    function automatic logic [35:0] waves(input int a, input int b, input int c);
        return {12'(c), 12'(b), 12'(a)};
    endfunction

    function automatic logic [23:0] exp_data();
        return {m_byte[2], m_byte[1], m_byte[0]};
    endfunction

    task automatic model_clear();
        for (int v = 0; v < 3; v++) begin
            m_pend[v] = 0; m_mode[v] = 0; m_idx[v] = 0; m_byte[v] = 8'h00;
        end
        m_last = 2;
        cyc    = 0;
        m_ov   = '0;
        m_ovr  = '0;
        sched.delete();
    endtask

    task automatic model_step(input logic [2:0] rv, input logic [5:0] md,
                              input logic [35:0] wv);
        int g, c;
        if (reset) begin
            model_clear();
            return;
        end
        cyc++;
        m_ov  = '0;
        m_ovr = '0;
        while (sched.size() > 0 && sched[0].due == cyc) begin
            m_ov[sched[0].v]   = 1'b1;
            m_byte[sched[0].v] = 8'(sched[0].val);
            void'(sched.pop_front());
        end
        g = -1;
        for (int k = 0; k < 3; k++) begin
            c = (m_last + 1 + k) % 3;
            if (g < 0 && m_pend[c] != 0) g = c;
        end
        if (g >= 0) begin
            sched.push_back('{cyc + 2, g, ref_byte(m_mode[g], m_idx[g])});
            m_last = g;
        end
        for (int v = 0; v < 3; v++) begin
            if (rv[v]) begin
                if (m_pend[v] != 0 && v != g) m_ovr[v] = 1'b1;
                m_pend[v] = 1;
                m_mode[v] = int'(md[2*v +: 2]);
                m_idx[v]  = int'(wv[12*v +: 12]);
            end else if (v == g) begin
                m_pend[v] = 0;
            end
        end
    endtask

    task automatic tick(input logic [2:0] rv, input logic [5:0] md,
                        input logic [35:0] wv);
        req_valid = rv; req_mode = md; req_wave = wv;
        @(posedge clock);
        model_step(rv, md, wv);
        #1;
        req_valid = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        tick('0, '0, '0);
        tick('0, '0, '0);
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        checks++;
        if (out_valid !== 3'b000 || overrun !== 3'b000)
            begin errors++; $display("FAIL reset_flags: got v=%b o=%b want 000/000", out_valid, overrun); end
        checks++;
        if (out_data !== 24'h0)
            begin errors++; $display("FAIL reset_data: got %h want 000000", out_data); end
        model_clear();
        tick(3'b111, 6'b0, waves(12'hFFF, 12'hFFF, 12'hFFF));   // ignored under reset
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick('0, '0, '0);
            checks++;
            if (out_valid !== 3'b000)
                begin errors++; $display("FAIL reset_ignore: cycle %0d got %b want 000", i, out_valid); end
        end
    endtask

    task automatic test_single();
        do_reset();
        tick(3'b001, 6'b0, waves(12'h0FF, 0, 0));
        for (int i = 1; i <= 3; i++) begin
            tick('0, '0, '0);
            checks++;
            if (i < 3) begin
                if (out_valid !== 3'b000)
                    begin errors++; $display("FAIL single_early: +%0d got %b want 000", i, out_valid); end
            end else begin
                if (out_valid !== 3'b001 || out_data[7:0] !== 8'h0F)
                    begin errors++; $display("FAIL single_hit: got v=%b d=%h want 001/0f", out_valid, out_data[7:0]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        tick(3'b001, 6'b0, waves(12'h07F, 0, 0));
        tick(3'b001, 6'b0, waves(12'hFFF, 0, 0));
        checks++;
        if (overrun !== 3'b000)
            begin errors++; $display("FAIL b2b_overrun: got %b want 000", overrun); end
        tick('0, '0, '0);
        tick('0, '0, '0);
        checks++;
        if (out_valid !== 3'b001 || out_data[7:0] !== 8'h03)
            begin errors++; $display("FAIL b2b_first: got v=%b d=%h want 001/03", out_valid, out_data[7:0]); end
        tick('0, '0, '0);
        checks++;
        if (out_valid !== 3'b001 || out_data[7:0] !== 8'hFF)
            begin errors++; $display("FAIL b2b_second: got v=%b d=%h want 001/ff", out_valid, out_data[7:0]); end
    endtask

    task automatic test_all_voices();
        logic [2:0] ev;
        do_reset();
        tick(3'b111, 6'b0, waves(12'h000, 12'h0FF, 12'hFFF));
        for (int j = 1; j <= 5; j++) begin
            tick('0, '0, '0);
            ev = (j == 3) ? 3'b001 : (j == 4) ? 3'b010 : (j == 5) ? 3'b100 : 3'b000;
            checks++;
            if (out_valid !== ev)
                begin errors++; $display("FAIL all_valid: +%0d got %b want %b", j, out_valid, ev); end
        end
        checks++;
        if (out_data !== 24'hFF0F00)
            begin errors++; $display("FAIL all_data: got %h want ff0f00", out_data); end
    endtask

    task automatic test_overrun();
        int n2;
        do_reset();
        tick(3'b111, 6'b0, waves(12'h010, 12'h020, 12'h0FF));
        tick(3'b100, 6'b0, waves(0, 0, 12'hFFF));
        checks++;
        if (overrun !== 3'b100)
            begin errors++; $display("FAIL ovr_pulse: got %b want 100", overrun); end
        n2 = 0;
        for (int j = 0; j < 6; j++) begin
            tick('0, '0, '0);
            if (j == 0) begin
                checks++;
                if (overrun !== 3'b000)
                    begin errors++; $display("FAIL ovr_width: got %b want 000", overrun); end
            end
            if (out_valid[2]) n2++;
        end
        checks++;
        if (n2 != 1 || out_data[23:16] !== 8'hFF)
            begin errors++; $display("FAIL ovr_deliver: got n=%0d d=%h want 1/ff", n2, out_data[23:16]); end
    endtask

    task automatic test_reset_midop();
        tick(3'b001, 6'b0, waves(12'h0FF, 0, 0));
        tick('0, '0, '0);
        reset = 1'b1;
        model_clear();
        #1;
        checks++;
        if (out_valid !== 3'b000 || overrun !== 3'b000 || out_data !== 24'h0)
            begin errors++; $display("FAIL midrst_clear: got v=%b o=%b d=%h want all 0", out_valid, overrun, out_data); end
        tick('0, '0, '0);
        tick('0, '0, '0);
        reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick('0, '0, '0);
            checks++;
            if (out_valid !== 3'b000 || out_data !== 24'h0)
                begin errors++; $display("FAIL midrst_quiet: +%0d got v=%b d=%h want 0", j, out_valid, out_data); end
        end
    endtask

    task automatic test_mode11();
        logic [7:0] want;
`ifdef SID_WAVE_PST_EN
        want = 8'h40;
`else
        want = 8'h00;
`endif
        do_reset();
        tick(3'b010, 6'b001100, waves(0, 12'hC00, 0));
        for (int j = 1; j <= 3; j++) begin
            tick('0, '0, '0);
            checks++;
            if (j < 3) begin
                if (out_valid !== 3'b000)
                    begin errors++; $display("FAIL m11_early: +%0d got %b want 000", j, out_valid); end
            end else begin
                if (out_valid !== 3'b010 || out_data[15:8] !== want)
                    begin errors++; $display("FAIL m11_hit: got v=%b d=%h want 010/%h", out_valid, out_data[15:8], want); end
            end
        end
    endtask

    task automatic test_wide();
        do_reset();
        w_req_valid = 2'b01; w_req_mode = '0; w_req_wave = {16'h0, 16'h0FF0};
        tick('0, '0, '0);
        w_req_valid = '0;
        for (int j = 1; j <= 3; j++) begin
            tick('0, '0, '0);
            checks++;
            if (j < 3) begin
                if (w_out_valid !== 2'b00)
                    begin errors++; $display("FAIL wide_early: +%0d got %b want 00", j, w_out_valid); end
            end else begin
                if (w_out_valid !== 2'b01 || w_out_data[11:0] !== 12'h0F0)
                    begin errors++; $display("FAIL wide_hit: got v=%b d=%h want 01/0f0", w_out_valid, w_out_data[11:0]); end
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  rv;
        logic [5:0]  md;
        logic [35:0] wv;
        do_reset();
        for (int i = 0; i < 406; i++) begin
            rv = (i < 400) ? 3'($urandom_range(0, 7) & $urandom_range(0, 7)) : 3'b000;
            md = 6'($urandom);
            wv = 36'({$urandom, $urandom});
            tick(rv, md, wv);
            checks++;
            if (out_valid !== m_ov)
                begin errors++; $display("FAIL rnd_valid: cyc %0d got %b want %b", i, out_valid, m_ov); end
            checks++;
            if (overrun !== m_ovr)
                begin errors++; $display("FAIL rnd_overrun: cyc %0d got %b want %b", i, overrun, m_ovr); end
            checks++;
            if (out_data !== exp_data())
                begin errors++; $display("FAIL rnd_data: cyc %0d got %h want %h", i, out_data, exp_data()); end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_back_to_back();
        test_all_voices();
        test_overrun();
        test_reset_midop();
        test_mode11();
        test_wide();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
